// File: rtl/ghash_pkg.sv
// GHASH shared definitions: reduction constant, FSM encoding, DIGIT check.
// The GHASH_LEN_BLOCK_EN macro adds the LEN state for the built-in length block.
package ghash_pkg;

  // 128-bit GF(2^128) element, index 0 = coefficient of x^0
  typedef logic [0:127] blk_t;

  // x^128 = 1 + x + x^2 + x^7 in GCM bit order
  localparam blk_t R_POLY = 128'hE1 << 120;

  localparam int unsigned LEN_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MULT
`ifdef GHASH_LEN_BLOCK_EN
    , ST_LEN
`endif
  } state_t;

  function automatic bit digit_legal(input int unsigned d);
    return d inside {1, 2, 4, 8, 16, 32, 64, 128};
  endfunction

endpackage

// File: rtl/ghash_if.sv
// GHASH block/key/result bus; master = producer, slave = ghash_block.
// The GHASH_LEN_BLOCK_EN macro adds the length-block signals.
interface ghash_if;
  import ghash_pkg::*;

  logic       iInit;
  blk_t       iHashKey;
  logic       iHashKey_valid;
  blk_t       iBlock;
  logic       iBlock_valid;
  logic       oReady;
  logic       oOverflow;
  blk_t       oResult;
  logic       oResult_valid;
`ifdef GHASH_LEN_BLOCK_EN
  logic       iAad;
  logic [7:0] iBlock_bits;
  logic       iFinal;
  logic       oLast;
`endif

  modport master (
    output iInit, iHashKey, iHashKey_valid, iBlock, iBlock_valid,
`ifdef GHASH_LEN_BLOCK_EN
    output iAad, iBlock_bits, iFinal,
    input  oLast,
`endif
    input  oReady, oOverflow, oResult, oResult_valid
  );

  modport slave (
    input  iInit, iHashKey, iHashKey_valid, iBlock, iBlock_valid,
`ifdef GHASH_LEN_BLOCK_EN
    input  iAad, iBlock_bits, iFinal,
    output oLast,
`endif
    output oReady, oOverflow, oResult, oResult_valid
  );

endinterface

// File: rtl/ghash_mul_step.sv
// One DIGIT-bit step of the right-shift GF(2^128) multiplier (purely combinational).
module ghash_mul_step
  import ghash_pkg::*;
#(
  parameter int unsigned DIGIT = 8
) (
  input  blk_t             z,
  input  blk_t             v,
  input  logic [0:DIGIT-1] x_digit,
  output blk_t             z_next,
  output blk_t             v_next
);

  blk_t z_acc;
  blk_t v_acc;

  // Bit-serial unrolled: accumulate V on set X bits, then multiply V by x
  always_comb begin
    z_acc = z;
    v_acc = v;
    for (int unsigned i = 0; i < DIGIT; i++) begin
      if (x_digit[i]) z_acc = z_acc ^ v_acc;
      v_acc = v_acc[127] ? ((v_acc >> 1) ^ R_POLY) : (v_acc >> 1);
    end
    z_next = z_acc;
    v_next = v_acc;
  end

endmodule

// File: rtl/ghash_block.sv
// GHASH accumulator Y = (Y ^ X) * H with one-entry input buffer.
// GHASH_LEN_BLOCK_EN: adds length counters and iFinal-driven length block.
module ghash_block
  import ghash_pkg::*;
#(
  parameter int unsigned DIGIT = 8
) (
  input  logic    iClk,
  input  logic    iRstn,
  ghash_if.slave  bus
);

  localparam int unsigned N = 128 / DIGIT;
  localparam logic [7:0]  LAST_CNT = 8'(N - 1);

  if (!digit_legal(DIGIT)) begin : g_digit_check
    $error("ghash_block: illegal DIGIT");
  end

  state_t     state, state_n;
  blk_t       h, y, z, v, xacc, buf_q;
  blk_t       z_next, v_next;
  logic       buf_full, overflow, result_valid;
  logic [7:0] cnt;
  logic       start_blk, start_len, busy, done, take_blk, drop_blk, load_h;
`ifdef GHASH_LEN_BLOCK_EN
  logic [LEN_W-1:0] len_a, len_c, blk_bits;
  logic             last_q;
`endif

  ghash_mul_step #(.DIGIT(DIGIT)) u_step (
    .z       (z),
    .v       (v),
    .x_digit (xacc[0:DIGIT-1]),
    .z_next  (z_next),
    .v_next  (v_next)
  );

  // FSM state register
  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) state <= ST_IDLE;
    else        state <= state_n;
  end

  // FSM next state; init aborts any multiply
  always_comb begin
    state_n = state;
    if (bus.iInit) state_n = ST_IDLE;
    else begin
      unique case (state)
        ST_IDLE: begin
          if (start_blk)      state_n = ST_MULT;
`ifdef GHASH_LEN_BLOCK_EN
          else if (start_len) state_n = ST_LEN;
`endif
        end
        default: if (cnt == LAST_CNT) state_n = ST_IDLE;
      endcase
    end
  end

  // FSM outputs: datapath controls; a draining buffer can accept a new block
  always_comb begin
    busy      = (state != ST_IDLE);
    start_blk = (state == ST_IDLE) && buf_full;
    start_len = 1'b0;
`ifdef GHASH_LEN_BLOCK_EN
    start_len = (state == ST_IDLE) && !buf_full && bus.iFinal;
`endif
    done      = busy && (cnt == LAST_CNT);
    take_blk  = bus.iBlock_valid && (!buf_full || start_blk);
    drop_blk  = bus.iBlock_valid && buf_full && !start_blk;
    load_h    = (state == ST_IDLE) && bus.iHashKey_valid;
  end

  // Datapath: key, buffer, multiplier registers, accumulator
  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      h            <= '0;
      y            <= '0;
      z            <= '0;
      v            <= '0;
      xacc         <= '0;
      buf_q        <= '0;
      buf_full     <= 1'b0;
      overflow     <= 1'b0;
      result_valid <= 1'b0;
      cnt          <= '0;
    end else if (bus.iInit) begin
      y            <= '0;
      buf_full     <= 1'b0;
      overflow     <= 1'b0;
      result_valid <= 1'b0;
      cnt          <= '0;
    end else begin
      result_valid <= done;
      if (load_h) h <= bus.iHashKey;
      if (take_blk) begin
        buf_q    <= bus.iBlock;
        buf_full <= 1'b1;
      end else if (start_blk) begin
        buf_full <= 1'b0;
      end
      if (drop_blk) overflow <= 1'b1;
      if (start_blk) begin
        z    <= '0;
        v    <= h;
        xacc <= y ^ buf_q;
        cnt  <= '0;
`ifdef GHASH_LEN_BLOCK_EN
      end else if (start_len) begin
        z    <= '0;
        v    <= h;
        xacc <= y ^ {len_a, len_c};
        cnt  <= '0;
`endif
      end else if (busy) begin
        z    <= z_next;
        v    <= v_next;
        xacc <= xacc << DIGIT;
        cnt  <= cnt + 8'd1;
        if (done) y <= z_next;
      end
    end
  end

`ifdef GHASH_LEN_BLOCK_EN
  assign blk_bits = (bus.iBlock_bits == 8'd0) ? 64'd128 : {56'd0, bus.iBlock_bits};

  // Bit-length counters and last-result flag
  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      len_a  <= '0;
      len_c  <= '0;
      last_q <= 1'b0;
    end else if (bus.iInit) begin
      len_a  <= '0;
      len_c  <= '0;
      last_q <= 1'b0;
    end else begin
      last_q <= done && (state == ST_LEN);
      if (take_blk) begin
        if (bus.iAad) len_a <= len_a + blk_bits;
        else          len_c <= len_c + blk_bits;
      end
    end
  end

  assign bus.oLast = last_q;
`endif

  assign bus.oReady        = !buf_full;
  assign bus.oOverflow     = overflow;
  assign bus.oResult       = y;
  assign bus.oResult_valid = result_valid;

endmodule

// File: tb/tb_ghash_block.sv
// Table-driven bench for ghash_block; three instances (DIGIT 1, 8, 128) share stimulus.
module tb_ghash_block;

  logic iClk  = 1'b0;
  logic iRstn = 1'b0;
  always #5 iClk = ~iClk;

  ghash_if if1 ();
  ghash_if if8 ();
  ghash_if if128 ();

  ghash_block #(.DIGIT(1))   dut1   (.iClk(iClk), .iRstn(iRstn), .bus(if1));
  ghash_block #(.DIGIT(8))   dut8   (.iClk(iClk), .iRstn(iRstn), .bus(if8));
  ghash_block #(.DIGIT(128)) dut128 (.iClk(iClk), .iRstn(iRstn), .bus(if128));

  typedef struct {
    logic         do_init;
    logic [127:0] h;
    logic [127:0] x;
    logic [127:0] y;
  } vec_t;

  localparam logic [127:0] H_TC2 = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] X1    = 128'h0388dace60b6a392f328c2b971b2fe78;
  localparam logic [127:0] Y1    = 128'h5e2ec746917062882c85b0685353deb7;
  localparam logic [127:0] X2    = 128'h00000000000000000000000000000080;
  localparam logic [127:0] Y2    = 128'hf38cbb1ad69223dcc3457ae5b6b0f885;
  localparam logic [127:0] ONE   = 128'h80000000000000000000000000000000;
  localparam logic [127:0] XPOLY = 128'h40000000000000000000000000000000;

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  task automatic drive(input logic init, input logic [127:0] hk, input logic hkv,
                       input logic [127:0] blk, input logic bv);
    if1.iInit = init;   if1.iHashKey = hk;   if1.iHashKey_valid = hkv;
    if1.iBlock = blk;   if1.iBlock_valid = bv;
    if8.iInit = init;   if8.iHashKey = hk;   if8.iHashKey_valid = hkv;
    if8.iBlock = blk;   if8.iBlock_valid = bv;
    if128.iInit = init; if128.iHashKey = hk; if128.iHashKey_valid = hkv;
    if128.iBlock = blk; if128.iBlock_valid = bv;
  endtask

  task automatic init_pulse();
    drive(1'b1, '0, 1'b0, '0, 1'b0);
    step();
    drive(1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic load_key(input logic [127:0] hk);
    drive(1'b0, hk, 1'b1, '0, 1'b0);
    step();
    drive(1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic strobe(input logic [127:0] blk);
    drive(1'b0, '0, 1'b0, blk, 1'b1);
    step();
    drive(1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  // Cycles after the strobe edge until each first oResult_valid; 0 = never seen
  task automatic wait_all(input int unsigned limit, output int unsigned l1,
                          output int unsigned l8, output int unsigned l128);
    l1 = 0; l8 = 0; l128 = 0;
    for (int unsigned c = 1; c <= limit; c++) begin
      step();
      if (if1.oResult_valid   && l1 == 0)   l1 = c;
      if (if8.oResult_valid   && l8 == 0)   l8 = c;
      if (if128.oResult_valid && l128 == 0) l128 = c;
      if (l1 != 0 && l8 != 0 && l128 != 0) break;
    end
  endtask

  task automatic count_pulses8(input int unsigned ncyc, output int unsigned n);
    n = 0;
    for (int unsigned c = 0; c < ncyc; c++) begin
      step();
      if (if8.oResult_valid) n++;
    end
  endtask

  vec_t        vecs[7];
  int unsigned l1, l8, l128, np;

  initial begin
    vecs[0] = '{1'b1, ONE,   128'h0123456789abcdef0011223344556677,
                         128'h0123456789abcdef0011223344556677};
    vecs[1] = '{1'b0, ONE,   128'h0123456789abcdef0011223344556677, 128'h0};
    vecs[2] = '{1'b1, XPOLY, 128'h00000000000000000000000000000001,
                         128'he1000000000000000000000000000000};
    vecs[3] = '{1'b1, XPOLY, ONE, XPOLY};
    vecs[4] = '{1'b1, H_TC2, ONE, H_TC2};
    vecs[5] = '{1'b1, H_TC2, X1,  Y1};
    vecs[6] = '{1'b0, H_TC2, X2,  Y2};

`ifdef GHASH_LEN_BLOCK_EN
    if1.iAad = 1'b0;   if1.iBlock_bits = 8'd0;   if1.iFinal = 1'b0;
    if8.iAad = 1'b0;   if8.iBlock_bits = 8'd0;   if8.iFinal = 1'b0;
    if128.iAad = 1'b0; if128.iBlock_bits = 8'd0; if128.iFinal = 1'b0;
`endif
    drive(1'b0, '0, 1'b0, '0, 1'b0);
    repeat (3) step();
    chk("rst_ready",    {127'd0, if8.oReady},        128'd1);
    chk("rst_overflow", {127'd0, if8.oOverflow},     128'd0);
    chk("rst_result",   if8.oResult,                 128'd0);
    chk("rst_valid",    {127'd0, if8.oResult_valid}, 128'd0);
    iRstn = 1'b1;
    step();

    // Vector table across all three digit widths
    for (int unsigned t = 0; t < 7; t++) begin
      if (vecs[t].do_init) init_pulse();
      load_key(vecs[t].h);
      strobe(vecs[t].x);
      wait_all(200, l1, l8, l128);
      chk($sformatf("vec%0d_y_d1", t),   if1.oResult,   vecs[t].y);
      chk($sformatf("vec%0d_y_d8", t),   if8.oResult,   vecs[t].y);
      chk($sformatf("vec%0d_y_d128", t), if128.oResult, vecs[t].y);
      chk($sformatf("vec%0d_lat_d1", t),   128'(l1),   128'd129);
      chk($sformatf("vec%0d_lat_d8", t),   128'(l8),   128'd17);
      chk($sformatf("vec%0d_lat_d128", t), 128'(l128), 128'd2);
    end

    // Three consecutive strobes: first starts, second buffered, third dropped
    init_pulse();
    load_key(H_TC2);
    drive(1'b0, '0, 1'b0, X1, 1'b1);
    step();
    drive(1'b0, '0, 1'b0, X2, 1'b1);
    step();
    drive(1'b0, '0, 1'b0, 128'hffffffffffffffffffffffffffffffff, 1'b1);
    step();
    drive(1'b0, '0, 1'b0, '0, 1'b0);
    chk("ovf_flag",  {127'd0, if8.oOverflow}, 128'd1);
    chk("ovf_ready", {127'd0, if8.oReady},    128'd0);
    count_pulses8(60, np);
    chk("ovf_pulses", 128'(np), 128'd2);
    chk("ovf_y",      if8.oResult, Y2);

    // Init during MULT with a same-cycle block strobe
    strobe(X1);
    repeat (5) step();
    drive(1'b1, '0, 1'b0, X2, 1'b1);
    step();
    drive(1'b0, '0, 1'b0, '0, 1'b0);
    chk("init_y",        if8.oResult,             128'd0);
    chk("init_ready",    {127'd0, if8.oReady},    128'd1);
    chk("init_overflow", {127'd0, if8.oOverflow}, 128'd0);
    count_pulses8(30, np);
    chk("init_pulses", 128'(np), 128'd0);
    strobe(X1);
    wait_all(200, l1, l8, l128);
    chk("init_hkept_y",   if8.oResult, Y1);
    chk("init_hkept_lat", 128'(l8),    128'd17);

    // Asynchronous reset at cnt=5 with a second block buffered
    strobe(X1);
    step();
    step();
    strobe(X2);
    repeat (3) step();
    chk("mid_ready_busy", {127'd0, if8.oReady}, 128'd0);
    #2;
    iRstn = 1'b0;
    #1;
    chk("arst_result",   if8.oResult,                 128'd0);
    chk("arst_ready",    {127'd0, if8.oReady},        128'd1);
    chk("arst_overflow", {127'd0, if8.oOverflow},     128'd0);
    chk("arst_valid",    {127'd0, if8.oResult_valid}, 128'd0);
    repeat (3) step();
    iRstn = 1'b1;
    count_pulses8(40, np);
    chk("arst_pulses",     128'(np),    128'd0);
    chk("arst_result_end", if8.oResult, 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
